// File: rtl/rv32_decode_buffer.sv
// rtl/rv32_decode_buffer.sv - RV32 fetch realigner, predecoder and DEPTH-entry instruction queue
// Define RV32_DECODE_BUFFER_RVC_EN to build the 16/32-bit aligner and compressed detection.
module rv32_decode_buffer #(
  parameter int DEPTH    = 4,
  parameter int NUM_READ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [31:0]         fetch_data,
  input  logic [31:0]         fetch_pc,
  input  logic                flush,
  input  logic                flush_half,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_pc,
  output logic                out_compressed,
  output logic [3:0]          out_class,
  output logic [NUM_READ-1:0] out_use_rs,
  output logic [4:0]          out_rd,
  output logic                out_wb,
  output logic                out_invalid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] CLS_LUI = 4'd0, CLS_AUIPC = 4'd1, CLS_JAL = 4'd2, CLS_JALR = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4, CLS_OP_IMM = 4'd5, CLS_OP = 4'd6, CLS_STORE = 4'd7;
  localparam logic [3:0] CLS_LOAD = 4'd8, CLS_SYSTEM = 4'd9, CLS_CMP = 4'd10, CLS_INVALID = 4'd11;

  logic [31:0]    instr_q [DEPTH];
  logic [31:0]    pc_q    [DEPTH];
  logic [DEPTH-1:0] cmp_q;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           accept, pop;
  logic [1:0]     n_push;
  logic [31:0]    p0_instr, p0_pc, p1_instr, p1_pc;
  logic           p0_cmp, p1_cmp;

  assign accept = fetch_valid && fetch_ready;
  assign pop    = out_valid && out_ready;

`ifdef RV32_DECODE_BUFFER_RVC_EN
  localparam int NEED = 2;

  logic        hold_valid_q, hold_valid_d, skip_q, skip_d;
  logic [15:0] hold_half_q, hold_half_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        lo_valid, lo_cmp, up_free, up_emit;
  logic [31:0] lo_instr, lo_pc;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_half_d  = hold_half_q;
    hold_pc_d    = hold_pc_q;
    skip_d       = skip_q;
    lo_valid = 1'b0;
    lo_cmp   = 1'b0;
    lo_instr = 32'd0;
    lo_pc    = 32'd0;
    up_free  = 1'b0;
    up_emit  = 1'b0;
    n_push   = 2'd0;
    p0_instr = 32'd0;
    p0_pc    = 32'd0;
    p0_cmp   = 1'b0;
    p1_instr = 32'd0;
    p1_pc    = 32'd0;
    p1_cmp   = 1'b0;
    if (accept) begin
      skip_d  = 1'b0;
      up_free = 1'b1;
      if (hold_valid_q) begin
        lo_valid     = 1'b1;
        lo_instr     = {fetch_data[15:0], hold_half_q};
        lo_pc        = hold_pc_q;
        hold_valid_d = 1'b0;
      end else if (!skip_q) begin
        lo_valid = 1'b1;
        lo_pc    = fetch_pc;
        if (fetch_data[1:0] != 2'b11) begin
          lo_instr = {16'h0, fetch_data[15:0]};
          lo_cmp   = 1'b1;
        end else begin
          lo_instr = fetch_data;
          up_free  = 1'b0;
        end
      end
      if (up_free) begin
        if (fetch_data[17:16] != 2'b11) begin
          up_emit = 1'b1;
        end else begin
          hold_valid_d = 1'b1;
          hold_half_d  = fetch_data[31:16];
          hold_pc_d    = fetch_pc + 32'd2;
        end
      end
      // Lower address always occupies the first slot so queue order follows pc order.
      if (lo_valid) begin
        p0_instr = lo_instr;
        p0_pc    = lo_pc;
        p0_cmp   = lo_cmp;
        p1_instr = {16'h0, fetch_data[31:16]};
        p1_pc    = fetch_pc + 32'd2;
        p1_cmp   = 1'b1;
        n_push   = up_emit ? 2'd2 : 2'd1;
      end else if (up_emit) begin
        p0_instr = {16'h0, fetch_data[31:16]};
        p0_pc    = fetch_pc + 32'd2;
        p0_cmp   = 1'b1;
        n_push   = 2'd1;
      end
    end
    if (flush) begin
      hold_valid_d = 1'b0;
      skip_d       = flush_half;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_half_q  <= 16'd0;
      hold_pc_q    <= 32'd0;
      skip_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_half_q  <= hold_half_d;
      hold_pc_q    <= hold_pc_d;
      skip_q       <= skip_d;
    end
  end
`else
  localparam int NEED = 1;

  logic unused_flush_half;
  assign unused_flush_half = flush_half;

  assign n_push   = accept ? 2'd1 : 2'd0;
  assign p0_instr = fetch_data;
  assign p0_pc    = fetch_pc;
  assign p0_cmp   = 1'b0;
  assign p1_instr = 32'd0;
  assign p1_pc    = 32'd0;
  assign p1_cmp   = 1'b0;
`endif

  // Credit comes only from the registered count; a pop in the same cycle does not open space.
  assign fetch_ready = !rst && (count_q <= CW'(DEPTH - NEED));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (n_push != 2'd0) begin
        instr_q[wr_ptr_q] <= p0_instr;
        pc_q[wr_ptr_q]    <= p0_pc;
        cmp_q[wr_ptr_q]   <= p0_cmp;
      end
      if (n_push == 2'd2) begin
        instr_q[wr_ptr_q + PW'(1)] <= p1_instr;
        pc_q[wr_ptr_q + PW'(1)]    <= p1_pc;
        cmp_q[wr_ptr_q + PW'(1)]   <= p1_cmp;
      end
    end
  end

  logic [31:0] head_instr, head_pc;
  logic        head_cmp, head_wb;
  logic [3:0]  head_class;
  logic [1:0]  head_use;

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_cmp   = cmp_q[rd_ptr_q];

  always_comb begin
    head_class = CLS_INVALID;
    head_use   = 2'b00;
    head_wb    = 1'b0;
    if (head_cmp) begin
      head_class = CLS_CMP;
    end else begin
      case (head_instr[6:0])
        7'b0110111: begin head_class = CLS_LUI;    head_wb = 1'b1; end
        7'b0010111: begin head_class = CLS_AUIPC;  head_wb = 1'b1; end
        7'b1101111: begin head_class = CLS_JAL;    head_wb = 1'b1; end
        7'b1100111: begin head_class = CLS_JALR;   head_wb = 1'b1; head_use = 2'b01; end
        7'b1100011: begin head_class = CLS_BRANCH; head_use = 2'b11; end
        7'b0010011: begin head_class = CLS_OP_IMM; head_wb = 1'b1; head_use = 2'b01; end
        7'b0110011: begin head_class = CLS_OP;     head_wb = 1'b1; head_use = 2'b11; end
        7'b0100011: begin head_class = CLS_STORE;  head_use = 2'b11; end
        7'b0000011: begin head_class = CLS_LOAD;   head_wb = 1'b1; head_use = 2'b01; end
        7'b1110011: begin head_class = CLS_SYSTEM; head_wb = 1'b1; head_use = 2'b01; end
        default:    head_class = CLS_INVALID;
      endcase
    end
  end

  assign out_valid      = !rst && (count_q != '0);
  assign out_instr      = out_valid ? head_instr : 32'd0;
  assign out_pc         = out_valid ? head_pc : 32'd0;
  assign out_compressed = out_valid && head_cmp;
  assign out_class      = out_valid ? head_class : 4'd0;
  assign out_use_rs     = out_valid ? NUM_READ'(head_use) : '0;
  assign out_rd         = out_valid ? head_instr[11:7] : 5'd0;
  assign out_wb         = out_valid && head_wb && (head_instr[11:7] != 5'd0);
  assign out_invalid    = out_valid && ((head_class == CLS_INVALID) || (head_class == CLS_CMP));
endmodule

// File: tb/tb_rv32_decode_buffer.sv
// tb/tb_rv32_decode_buffer.sv - scoreboard bench for rv32_decode_buffer with a halfword-stream reference model
module tb_rv32_decode_buffer;
  localparam int DEPTH = 4;
`ifdef RV32_DECODE_BUFFER_RVC_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0, fetch_ready;
  logic [31:0] fetch_data = 32'd0, fetch_pc = 32'd0;
  logic        flush = 1'b0, flush_half = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic        out_compressed, out_wb, out_invalid;
  logic [3:0]  out_class;
  logic [1:0]  out_use_rs;
  logic [4:0]  out_rd;

  rv32_decode_buffer #(.DEPTH(DEPTH), .NUM_READ(2)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .flush(flush), .flush_half(flush_half),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_compressed(out_compressed),
    .out_class(out_class), .out_use_rs(out_use_rs), .out_rd(out_rd),
    .out_wb(out_wb), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; logic cmp; } exp_t;
  typedef struct { logic [31:0] pc; logic [15:0] h; } half_t;

  exp_t  sb[$];
  half_t halves[$];
  bit    m_skip = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference predecode: {class, use_rs, wb, invalid}
  function automatic logic [7:0] ref_decode(input logic [31:0] ins, input logic cmp);
    logic [3:0] c;
    logic [1:0] u;
    logic       w;
    if (cmp) return {4'd10, 2'b00, 1'b0, 1'b1};
    u = 2'b00;
    w = 1'b0;
    case (ins[6:0])
      7'h37: begin c = 4'd0; w = 1'b1; end
      7'h17: begin c = 4'd1; w = 1'b1; end
      7'h6F: begin c = 4'd2; w = 1'b1; end
      7'h67: begin c = 4'd3; w = 1'b1; u = 2'b01; end
      7'h63: begin c = 4'd4; u = 2'b11; end
      7'h13: begin c = 4'd5; w = 1'b1; u = 2'b01; end
      7'h33: begin c = 4'd6; w = 1'b1; u = 2'b11; end
      7'h23: begin c = 4'd7; u = 2'b11; end
      7'h03: begin c = 4'd8; w = 1'b1; u = 2'b01; end
      7'h73: begin c = 4'd9; w = 1'b1; u = 2'b01; end
      default: c = 4'd11;
    endcase
    return {c, u, w && (ins[11:7] != 5'd0), c == 4'd11};
  endfunction

  // Fetch words are modelled as a stream of halfwords: each compressed half or matching pair leaves the stream.
  task automatic model_word(input logic [31:0] d, input logic [31:0] p);
`ifdef RV32_DECODE_BUFFER_RVC_EN
    half_t a, b;
    if (m_skip) m_skip = 1'b0;
    else halves.push_back('{p, d[15:0]});
    halves.push_back('{p + 32'd2, d[31:16]});
    while (halves.size() != 0) begin
      a = halves[0];
      if (a.h[1:0] != 2'b11) begin
        sb.push_back('{{16'h0, a.h}, a.pc, 1'b1});
        void'(halves.pop_front());
      end else if (halves.size() >= 2) begin
        b = halves[1];
        sb.push_back('{{b.h, a.h}, a.pc, 1'b0});
        void'(halves.pop_front());
        void'(halves.pop_front());
      end else begin
        break;
      end
    end
`else
    sb.push_back('{d, p, 1'b0});
`endif
  endtask

  task automatic model_flush(input logic fh);
    sb.delete();
    halves.delete();
`ifdef RV32_DECODE_BUFFER_RVC_EN
    m_skip = fh;
`else
    m_skip = 1'b0 & fh;
`endif
  endtask

  // One clock: inputs are driven just after a rising edge, acceptance is judged mid-cycle.
  task automatic step(input logic fv, input logic [31:0] d, input logic [31:0] p,
                      input logic fl, input logic fh, output bit acc);
    fetch_valid = fv;
    fetch_data  = d;
    fetch_pc    = p;
    flush       = fl;
    flush_half  = fh;
    @(negedge clk);
    acc = fv && fetch_ready && !fl;
    @(posedge clk);
    if (fl) model_flush(fh);
    else if (acc) model_word(d, p);
    #1;
    fetch_valid = 1'b0;
    flush = 1'b0;
    flush_half = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 11))
      0: return 7'h37;  1: return 7'h17;  2: return 7'h6F;  3: return 7'h67;
      4: return 7'h63;  5: return 7'h13;  6: return 7'h33;  7: return 7'h23;
      8: return 7'h03;  9: return 7'h73;  default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = rand_op();
    if ($urandom_range(0, 2) == 0) w[1:0] = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 0) w[22:16] = rand_op();
    if ($urandom_range(0, 2) == 0) w[17:16] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  exp_t        me;
  logic [7:0]  md;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fetch_ready", fetch_ready, 0);
    end else begin
      chk("fetch_ready", fetch_ready, (DEPTH - sb.size()) >= NEED);
      chk("out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
        me = sb[0];
        md = ref_decode(me.instr, me.cmp);
        chk("out_instr", out_instr, me.instr);
        chk("out_pc", out_pc, me.pc);
        chk("out_compressed", out_compressed, me.cmp);
        chk("out_class", out_class, md[7:4]);
        chk("out_use_rs", out_use_rs, md[3:2]);
        chk("out_rd", out_rd, me.instr[11:7]);
        chk("out_wb", out_wb, md[1]);
        chk("out_invalid", out_invalid, md[0]);
        if (out_ready) void'(sb.pop_front());
      end else if (!out_valid) begin
        chk("empty_fields_zero", (|out_instr) || (|out_pc) || out_compressed || (|out_class) ||
            (|out_use_rs) || (|out_rd) || out_wb || out_invalid, 0);
      end
    end
  end

  initial begin
    bit          acc;
    int          n;
    logic [31:0] pc;
    logic [31:0] w;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", fetch_ready, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0, acc);
    chk("first_accept", acc, 1);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("opimm_class", out_class, 4'd5);
    chk("opimm_wb", out_wb, 1);
    @(posedge clk);
    #1;
    if (sb.size() != 0) void'(sb.pop_front());
    step(1'b1, 32'h0020A023, 32'h104, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00000013, 32'h108, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0000007F, 32'h10C, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00938082, 32'h200, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00010050, 32'h204, 1'b0, 1'b0, acc);
    drain();

    out_ready = 1'b0;
    n = 0;
    pc = 32'h500;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h00100093 | (32'(i) << 20), pc, 1'b0, 1'b0, acc);
      if (!acc) break;
      n++;
      pc += 32'd4;
    end
    chk("backpressure_accepted", n, DEPTH - NEED + 1);
    drain();

    out_ready = 1'b0;
    step(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00500093, 32'h404, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00938082, 32'h408, 1'b0, 1'b0, acc);
    chk("pre_flush_depth", sb.size(), 3);
    step(1'b1, 32'h00000013, 32'h40C, 1'b1, 1'b1, acc);
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00A00113, 32'h304, 1'b0, 1'b0, acc);
    drain();

    out_ready = 1'b0;
    step(1'b1, 32'h00100093, 32'h600, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00200113, 32'h604, 1'b0, 1'b0, acc);
    out_ready = 1'b1;
    step(1'b1, 32'h00300193, 32'h608, 1'b0, 1'b0, acc);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_depth", sb.size(), 2);
    chk("pushpop_head_pc", out_pc, 32'h604);
    @(posedge clk);
    #1;
    drain();

    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        step(1'b1, rand_word(), pc, 1'b1, 1'($urandom_range(0, 1)), acc);
        pc = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
      end else begin
        w = rand_word();
        step(1'($urandom_range(0, 3) != 0), w, pc, 1'b0, 1'b0, acc);
        if (acc) pc += 32'd4;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
